// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the dual-clock FIFO: pops words, hides the one-cycle read
// latency behind a 2-entry buffer, and offers a valid/ready stream with flush/drain.
module fifo_stream_reader #(
  parameter int DATA_SIZE = 8,
  parameter int CNT_SIZE  = 16
) (
  input  logic                 rclk,
  input  logic                 rrst,
  input  logic                 enable,
  input  logic                 flush,
  input  logic                 rEmpty,
  input  logic [DATA_SIZE-1:0] rData,
  output logic                 rinc,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_SIZE-1:0] m_data,
  output logic                 busy,
  output logic                 flush_done,
  output logic [CNT_SIZE-1:0]  rd_count,
  output logic [CNT_SIZE-1:0]  drop_count
);

  // state | meaning
  // IDLE  | no pops; buffered and in-flight words still drain to the stream
  // RUN   | pop whenever the buffer can absorb the word in flight
  // FLUSH | buffer discarded, FIFO popped to empty, every word counted as dropped
  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t               state, state_nxt;
  logic [1:0]           occ;
  logic                 pend;
  logic [DATA_SIZE-1:0] ent0, ent1;
  logic                 pop;
  logic                 flush_entry;
  logic [2:0]           fill;
  logic [1:0]           tail;
  logic [1:0]           drop_num;
  logic [CNT_SIZE:0]    rd_sum;
  logic [CNT_SIZE:0]    drop_sum;

  assign m_valid     = (occ != 2'd0) && (state != FLUSH);
  assign m_data      = ent0;
  assign pop         = m_valid && m_ready;
  assign fill        = {1'b0, occ} + {2'b00, pend} - {2'b00, pop};
  assign tail        = occ - {1'b0, pop};
  assign flush_entry = flush && (state != FLUSH);
  assign busy        = (state != IDLE) || (occ != 2'd0) || pend;

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    rinc       = 1'b0;
    flush_done = 1'b0;
    case (state)
      IDLE: begin
        if (flush)       state_nxt = FLUSH;
        else if (enable) state_nxt = RUN;
      end
      RUN: begin
        // enable gates rinc directly so pops stop in the cycle enable falls
        rinc = enable && !rEmpty && (fill < 3'd2);
        if (flush)        state_nxt = FLUSH;
        else if (!enable) state_nxt = IDLE;
      end
      FLUSH: begin
        rinc = !rEmpty;
        if (rEmpty && !pend) begin
          state_nxt  = IDLE;
          flush_done = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // On flush entry everything not popped this cycle (buffer plus the word in flight) is dropped
  always_comb begin
    drop_num = 2'd0;
    if (flush_entry)         drop_num = fill[1:0];
    else if (state == FLUSH) drop_num = {1'b0, pend};
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      occ  <= 2'd0;
      pend <= 1'b0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      pend <= rinc && !rEmpty;
      if (flush_entry || state == FLUSH) begin
        occ <= 2'd0;
      end else begin
        occ <= fill[1:0];
        if (pop) ent0 <= ent1;
        if (pend) begin
          if (tail == 2'd0) ent0 <= rData;
          else              ent1 <= rData;
        end
      end
    end
  end

  assign rd_sum   = {1'b0, rd_count} + {{CNT_SIZE{1'b0}}, pop};
  assign drop_sum = {1'b0, drop_count} + {{(CNT_SIZE-1){1'b0}}, drop_num};

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rd_count   <= '0;
      drop_count <= '0;
    end else begin
      rd_count   <= rd_sum[CNT_SIZE]   ? {CNT_SIZE{1'b1}} : rd_sum[CNT_SIZE-1:0];
      drop_count <= drop_sum[CNT_SIZE] ? {CNT_SIZE{1'b1}} : drop_sum[CNT_SIZE-1:0];
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: behavioural FIFO model plus an in-order
// scoreboard, with hand-computed expectations for each scenario.
module tb_fifo_stream_reader;

  logic        rclk = 1'b0;
  logic        rrst = 1'b1;
  logic        enable = 1'b0;
  logic        flush = 1'b0;
  logic        rEmpty = 1'b1;
  logic [7:0]  rData = 8'h00;
  logic        m_ready = 1'b0;
  logic        rinc, m_valid, busy, flush_done;
  logic [7:0]  m_data;
  logic [15:0] rd_count, drop_count;

  fifo_stream_reader #(.DATA_SIZE(8), .CNT_SIZE(16)) dut (
    .rclk(rclk), .rrst(rrst), .enable(enable), .flush(flush),
    .rEmpty(rEmpty), .rData(rData), .rinc(rinc),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy), .flush_done(flush_done),
    .rd_count(rd_count), .drop_count(drop_count)
  );

  always #5 rclk = ~rclk;

  logic [7:0] fq[$];
  logic [7:0] exp_q[$];
  int tests = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Registered-empty FIFO: data appears the cycle after an accepted pop
  always @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rEmpty <= 1'b1;
      fq.delete();
    end else begin
      if (rinc && !rEmpty) rData <= fq.pop_front();
      rEmpty <= (fq.size() == 0);
    end
  end

  int         cyc = 0;
  logic       sb_on = 1'b1;
  int         npop = 0, first_pop = 0, last_pop = 0;
  int         rinc_empty = 0, occ_ovf = 0, cap_ovf = 0, fd_pulses = 0, rinc_cnt = 0;
  logic       hold_v = 1'b0;
  logic [7:0] hold_d = 8'h00;

  always @(posedge rclk) cyc++;

  always @(negedge rclk) begin
    if (rrst) begin
      hold_v = 1'b0;
    end else begin
      if (rinc && rEmpty) rinc_empty++;
      if (dut.occ == 2'd3) occ_ovf++;
      if (dut.pend && dut.occ == 2'd2 && !(m_valid && m_ready)) cap_ovf++;
      if (flush_done) fd_pulses++;
      if (rinc) rinc_cnt++;
      if (hold_v && m_valid) chk("hold_stable", m_data, hold_d);
      hold_v = m_valid && !m_ready;
      hold_d = m_data;
      if (sb_on && m_valid && m_ready) begin
        if (exp_q.size() == 0) chk("sb_extra", 1, 0);
        else chk("sb_data", m_data, exp_q.pop_front());
        if (npop == 0) first_pop = cyc;
        last_pop = cyc;
        npop++;
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge rclk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    fq.push_back(d);
    exp_q.push_back(d);
  endtask

  logic [3:0]  pat = 4'b1001;
  logic [15:0] base, d0;
  int          rc0, fd0;

  initial begin
    tick(2);
    chk("rst_rinc", rinc, 0);
    chk("rst_valid", m_valid, 0);
    chk("rst_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fdone", flush_done, 0);
    chk("rst_rdcnt", rd_count, 0);
    chk("rst_dropcnt", drop_count, 0);
    rrst = 1'b0;
    tick(2);

    // 64-word stream at full rate
    for (int i = 1; i <= 64; i++) push(i[7:0]);
    npop = 0;
    enable = 1'b1;
    m_ready = 1'b1;
    for (int k = 0; k < 300 && rd_count != 16'd64; k++) tick();
    chk("stream_cnt", rd_count, 64);
    chk("stream_npop", npop, 64);
    chk("stream_rate", last_pop - first_pop, 63);
    enable = 1'b0;
    tick(3);
    chk("stream_busy", busy, 0);
    chk("stream_left", exp_q.size(), 0);
    m_ready = 1'b0;

    // latency: T is the first cycle in RUN
    push(8'hA5);
    tick(2);
    chk("lat_idle_rinc", rinc, 0);
    enable = 1'b1;
    tick();
    chk("lat_rinc_T", rinc, 1);
    chk("lat_valid_T", m_valid, 0);
    tick();
    chk("lat_valid_T1", m_valid, 0);
    tick();
    chk("lat_valid_T2", m_valid, 1);
    chk("lat_data_T2", m_data, 8'hA5);
    m_ready = 1'b1;
    tick();
    enable = 1'b0;
    m_ready = 1'b0;
    tick(2);
    chk("lat_left", exp_q.size(), 0);

    // backpressure with m_ready pattern 1,0,0,1
    base = rd_count;
    for (int i = 0; i < 10; i++) push(8'h10 + i[7:0]);
    enable = 1'b1;
    for (int k = 0; k < 200 && exp_q.size() != 0; k++) begin
      m_ready = pat[k % 4];
      tick();
    end
    chk("bp_cnt", rd_count - base, 10);
    enable = 1'b0;
    m_ready = 1'b0;
    tick(3);
    chk("bp_busy", busy, 0);

    // disable with a full buffer: only buffered words come out
    base = rd_count;
    for (int i = 0; i < 10; i++) push(8'h30 + i[7:0]);
    enable = 1'b1;
    tick(7);
    chk("dis_occ", dut.occ, 2);
    chk("dis_pend", dut.pend, 0);
    rc0 = rinc_cnt;
    enable = 1'b0;
    m_ready = 1'b1;
    tick(5);
    chk("dis_rinc", rinc_cnt - rc0, 0);
    chk("dis_cnt", rd_count - base, 2);
    chk("dis_busy", busy, 0);
    chk("dis_fifo", fq.size(), 8);
    m_ready = 1'b0;

    // flush with 20 words outstanding (2 buffered + 18 in FIFO)
    for (int i = 0; i < 12; i++) push(8'h50 + i[7:0]);
    enable = 1'b1;
    tick(7);
    chk("fl_occ", dut.occ, 2);
    chk("fl_fifo_pre", fq.size(), 18);
    d0 = drop_count;
    fd0 = fd_pulses;
    sb_on = 1'b0;
    flush = 1'b1;
    enable = 1'b0;
    tick();
    flush = 1'b0;
    chk("fl_valid", m_valid, 0);
    for (int k = 0; k < 100 && fd_pulses == fd0; k++) tick();
    tick(3);
    chk("fl_drop", drop_count - d0, 20);
    chk("fl_done", fd_pulses - fd0, 1);
    chk("fl_fifo", fq.size(), 0);
    chk("fl_busy", busy, 0);
    exp_q.delete();
    sb_on = 1'b1;

    // asynchronous reset in mid-stream, then restart
    for (int i = 0; i < 10; i++) push(8'h60 + i[7:0]);
    enable = 1'b1;
    m_ready = 1'b1;
    tick(6);
    chk("rst_pre", rd_count != 16'd0, 1);
    #2 rrst = 1'b1;
    #1;
    chk("arst_rinc", rinc, 0);
    chk("arst_valid", m_valid, 0);
    chk("arst_rdcnt", rd_count, 0);
    chk("arst_dropcnt", drop_count, 0);
    chk("arst_busy", busy, 0);
    exp_q.delete();
    tick();
    rrst = 1'b0;
    tick(2);
    push(8'h77);
    push(8'h78);
    push(8'h79);
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) tick();
    chk("restart_cnt", rd_count, 3);
    enable = 1'b0;
    m_ready = 1'b0;
    tick(3);
    chk("restart_busy", busy, 0);

    chk("rinc_while_empty", rinc_empty, 0);
    chk("occ_over_2", occ_ovf, 0);
    chk("capture_full", cap_ovf, 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
